// File: rtl/led_pwm_blinker.sv
// led_pwm_blinker: multi-channel LED driver with OFF / ON / BLINK / PWM modes.
// All channels are stepped by one shared prescaled tick. The LED outputs and
// TICK are registered.
// Optional feature: define LED_PWM_BLINKER_BREATHE_EN to make PWM channels
// "breathe". Their duty then ramps up and down by one step per PWM frame.
// Without the macro, duty stays at the value last written.

module led_pwm_blinker #(
  parameter int NUM_CH     = 3,
  parameter int CNT_W      = 24,
  parameter int PWM_W      = 8,
  parameter int PRESCALE   = 12,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ENABLE,
  input  logic              CFG_WE,
  input  logic [3:0]        CFG_CH,
  input  logic [1:0]        CFG_MODE,
  input  logic [CNT_W-1:0]  CFG_PERIOD,
  input  logic [PWM_W-1:0]  CFG_DUTY,
  output logic              TICK,
  output logic [NUM_CH-1:0] LED
);

  localparam int              PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(PRESCALE - 1);
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;
  localparam logic [NUM_CH-1:0] DARK    = {NUM_CH{ACTIVE_LOW[0]}};

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_t;

  logic [PRE_W-1:0]  pre_cnt;
  logic [PWM_W-1:0]  pwm_cnt;
  logic              tick_int;
  logic              cfg_hit;
  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] state;

  // Internal tick fires on the last prescaler count, but only while running
  always_comb begin
    tick_int = ENABLE && (pre_cnt == PRE_MAX);
  end

  // Decode the config write. The full 4-bit index is compared, so any
  // out-of-range index selects no channel.
  always_comb begin
    cfg_hit = CFG_WE && (32'(CFG_CH) < NUM_CH);
    wr_sel  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = cfg_hit && (32'(CFG_CH) == i);
    end
  end

  // Shared prescaler, PWM frame counter and registered tick output
  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      TICK    <= 1'b0;
    end else begin
      TICK <= tick_int;
      if (ENABLE) begin
        pre_cnt <= tick_int ? '0 : pre_cnt + 1'b1;
      end
      if (tick_int) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mode_t            mode;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] cnt;
    logic [PWM_W-1:0] duty;
    logic             st;
`ifdef LED_PWM_BLINKER_BREATHE_EN
    logic             dir_up;
`endif

    assign state[g] = st;

    // Per-channel state. A config write to this channel takes priority over
    // a tick in the same cycle, so that tick is dropped for this channel only.
    always_ff @(posedge CLK) begin
      if (RST) begin
        mode   <= MODE_OFF;
        period <= '0;
        duty   <= '0;
        cnt    <= '0;
        st     <= 1'b0;
`ifdef LED_PWM_BLINKER_BREATHE_EN
        dir_up <= 1'b1;
`endif
      end else if (wr_sel[g]) begin
        mode   <= mode_t'(CFG_MODE);
        period <= CFG_PERIOD;
        duty   <= CFG_DUTY;
        cnt    <= '0;
        st     <= 1'b0;
`ifdef LED_PWM_BLINKER_BREATHE_EN
        dir_up <= 1'b1;
`endif
      end else if (tick_int) begin
        case (mode)
          MODE_OFF: st <= 1'b0;
          MODE_ON:  st <= 1'b1;
          MODE_BLINK: begin
            if (cnt == '0) begin
              cnt <= period;
              st  <= ~st;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          MODE_PWM: begin
            st <= (pwm_cnt < duty);
`ifdef LED_PWM_BLINKER_BREATHE_EN
            if (pwm_cnt == DUTY_MAX) begin
              if (dir_up) begin
                if (duty == DUTY_MAX) begin
                  duty   <= duty - 1'b1;
                  dir_up <= 1'b0;
                end else begin
                  duty <= duty + 1'b1;
                end
              end else begin
                if (duty == '0) begin
                  duty   <= duty + 1'b1;
                  dir_up <= 1'b1;
                end else begin
                  duty <= duty - 1'b1;
                end
              end
            end
`endif
          end
          default: st <= 1'b0;
        endcase
      end
    end
  end

  // LED pins follow channel state one clock later, with polarity applied
  always_ff @(posedge CLK) begin
    if (RST) begin
      LED <= DARK;
    end else begin
      LED <= state ^ DARK;
    end
  end

endmodule
